// File: rtl/line_fetch.sv
// line_fetch: fetches one 640-pixel line per scanline from SDRAM into a
// two-bank line buffer and serves pixels to the VGA scan-out one cycle later.
// Line T is written into bank T[0] while the display reads bank DrawY[0],
// so a fetch never disturbs the line being shown.
// Optional build macro: LINE_FETCH_BLANK_EN -- forces pixel_out to 0 outside
// the visible 640x480 area.
module line_fetch #(
  parameter logic [21:0] FB_BASE        = 22'h000000,
  parameter int          WORDS_PER_LINE = 80
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [9:0]   DrawX,
  input  logic [9:0]   DrawY,
  input  logic         new_frame,
  input  logic         lb_sdram_Wait,
  input  logic         lb_sdram_ac,
  input  logic [127:0] lb_sdram_data,
  output logic         lb_sdram_rd,
  output logic [21:0]  lb_sdram_addr,
  output logic         lb_Busy,
  output logic         lb_done,
  output logic [15:0]  pixel_out,
  output logic         lb_overrun
);

  typedef enum logic [1:0] {IDLE, REQ, LAST} state_t;

  state_t         state, state_next;
  logic [8:0]     line_t;      // target line being fetched
  logic [6:0]     word_w;      // next word of the line to request
  logic           trigger;
  logic [8:0]     trig_line;
  logic           accept;
  logic           last_word;
  logic [21:0]    fetch_addr;
  logic [127:0]   rd_word;
  logic [15:0]    pix_sel;
  logic           blank;

  logic [127:0]   buf_mem [0:1][0:WORDS_PER_LINE-1];

  // Fetch trigger at the end of each row: the last row wraps to line 0,
  // rows 0..478 prefetch the next row, rows 479..523 fetch nothing.
  assign trigger   = (DrawX == 10'd799) && ((DrawY == 10'd524) || (DrawY < 10'd479));
  assign trig_line = (DrawY == 10'd524) ? 9'd0 : (DrawY[8:0] + 9'd1);

  // lb_sdram_rd is only ever high in REQ, so an ack without a request is ignored.
  assign accept     = lb_sdram_rd & lb_sdram_ac;
  assign last_word  = (word_w == 7'(WORDS_PER_LINE - 1));
  assign fetch_addr = FB_BASE + 22'(line_t) * 22'(WORDS_PER_LINE) + 22'(word_w);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trigger) state_next = REQ;
      REQ:     if (accept && last_word) state_next = LAST;
      LAST:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs; the address is held steady because W only moves on an accept.
  always_comb begin
    lb_sdram_rd   = 1'b0;
    lb_sdram_addr = '0;
    lb_Busy       = 1'b0;
    lb_done       = 1'b0;
    case (state)
      REQ: begin
        lb_sdram_rd   = ~lb_sdram_Wait;
        lb_sdram_addr = fetch_addr;
        lb_Busy       = 1'b1;
      end
      LAST:    lb_done = (line_t == 9'd479);
      default: ;
    endcase
  end

  // Target line latch and word counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_t <= '0;
      word_w <= '0;
    end else if ((state == IDLE) && trigger) begin
      line_t <= trig_line;
      word_w <= '0;
    end else if (accept) begin
      word_w <= word_w + 7'd1;
    end
  end

  // Sticky overrun: a trigger outside IDLE is dropped; a set beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          lb_overrun <= 1'b0;
    else if (trigger && state != IDLE)  lb_overrun <= 1'b1;
    else if (new_frame)                 lb_overrun <= 1'b0;
  end

  // Line buffer write port: acknowledged words land in bank T[0].
  // NOTE: the buffer has no reset; its contents are don't-care until a line is fetched.
  always_ff @(posedge clk) begin
    if (accept) buf_mem[line_t[0]][word_w] <= lb_sdram_data;
  end

  // Display read: select the word and the 16-bit pixel; columns past the
  // buffered words read as zero rather than indexing outside the array.
  always_comb begin
    rd_word = '0;
    if (int'(DrawX[9:3]) < WORDS_PER_LINE) rd_word = buf_mem[DrawY[0]][DrawX[9:3]];
    pix_sel = rd_word[{DrawX[2:0], 4'b0000} +: 16];
`ifdef LINE_FETCH_BLANK_EN
    blank = (DrawX >= 10'd640) || (DrawY >= 10'd480);
`else
    blank = 1'b0;
`endif
  end

  // Pixel output register (one cycle after DrawX/DrawY).
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      pixel_out <= '0;
    else if (blank) pixel_out <= 16'h0000;
    else            pixel_out <= pix_sel;
  end

endmodule

// File: tb/tb_line_fetch.sv
// Self-checking bench for line_fetch: an SDRAM responder acks every third
// requested cycle; expected fetch addresses and pixels are queued when
// stimulus is driven and compared when the DUT produces them.
module tb_line_fetch;

  localparam logic [21:0] FB  = 22'h012340;
  localparam int          WPL = 80;

  logic         clk = 1'b0;
  logic         reset;
  logic [9:0]   DrawX, DrawY;
  logic         new_frame;
  logic         lb_sdram_Wait, lb_sdram_ac;
  logic [127:0] lb_sdram_data;
  logic         lb_sdram_rd;
  logic [21:0]  lb_sdram_addr;
  logic         lb_Busy, lb_done, lb_overrun;
  logic [15:0]  pixel_out;

  int n_cmp = 0;
  int n_bad = 0;
  logic [21:0] addr_q [$];
  logic [15:0] pix_q  [$];

  line_fetch #(.FB_BASE(FB), .WORDS_PER_LINE(WPL)) dut (
    .clk(clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .new_frame(new_frame),
    .lb_sdram_Wait(lb_sdram_Wait), .lb_sdram_ac(lb_sdram_ac), .lb_sdram_data(lb_sdram_data),
    .lb_sdram_rd(lb_sdram_rd), .lb_sdram_addr(lb_sdram_addr), .lb_Busy(lb_Busy),
    .lb_done(lb_done), .pixel_out(pixel_out), .lb_overrun(lb_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pixel k of word w of line L is {L-1 (6 bits), 8*w+k (10 bits)}, so the
  // pixel at column x of line L is {L-1, x} and line 1 word 0 is 0007_..._0000.
  function automatic logic [15:0] exp_pix(input int line, input int x);
    return {6'(line - 1), 10'(x)};
  endfunction

  function automatic logic [127:0] word_for(input logic [21:0] a);
    logic [127:0] r;
    int off, line, w;
    off  = int'(a - FB);
    line = off / WPL;
    w    = off % WPL;
    for (int k = 0; k < 8; k++) r[16*k +: 16] = exp_pix(line, w * 8 + k);
    return r;
  endfunction

  // Trigger a fetch from row y (target line t) and queue its addresses.
  task automatic start_line(input logic [9:0] y, input int t);
    for (int w = 0; w < WPL; w++) addr_q.push_back(FB + 22'(t * WPL + w));
    DrawY = y;
    DrawX = 10'd799;
    @(posedge clk); #1;
    DrawX = 10'd0;
    check("busy_rise", {63'd0, lb_Busy}, 64'd1);
  endtask

  // Serve read requests until lb_Busy falls (or stop_acks words are taken).
  // With stall_at >= 0, Wait is held high for 20 cycles once W reaches it,
  // while an ack is offered to confirm it is ignored without a request.
  task automatic serve(input int t, input int stall_at, input int stop_acks);
    int acks = 0, rd_cycles = 0, stall_left = 20, cyc = 0;
    logic [21:0] exp_a;
    bit fell = 0;
    while (!fell) begin
      lb_sdram_Wait = (stall_at >= 0 && acks == stall_at && stall_left > 0);
      if (lb_sdram_Wait) stall_left--;
      lb_sdram_ac = 1'b0;
      #1;
      if (lb_sdram_Wait) begin
        check("stall_rd", {63'd0, lb_sdram_rd}, 64'd0);
        check("stall_addr", {42'd0, lb_sdram_addr}, {42'd0, FB + 22'(t * WPL + stall_at)});
        lb_sdram_ac   = 1'b1;
        lb_sdram_data = {4{32'hDEADBEEF}};
      end else if (lb_sdram_rd) begin
        rd_cycles++;
        if (rd_cycles % 3 == 0) begin
          if (addr_q.size() == 0) begin
            check("addr_queue_empty", 64'd1, 64'd0);
          end else begin
            exp_a = addr_q.pop_front();
            check("rd_addr", {42'd0, lb_sdram_addr}, {42'd0, exp_a});
          end
          lb_sdram_ac   = 1'b1;
          lb_sdram_data = word_for(lb_sdram_addr);
          acks++;
        end
      end
      @(posedge clk); #1;
      lb_sdram_ac   = 1'b0;
      lb_sdram_Wait = 1'b0;
      cyc++;
      if (stop_acks >= 0 && acks == stop_acks) return;
      if (!lb_Busy) begin
        fell = 1;
        check("done_at_fall", {63'd0, lb_done}, {63'd0, (t == 479)});
      end else if (cyc > 2000) begin
        check("fetch_timeout", 64'd1, 64'd0);
        return;
      end
    end
    check("reads_per_line", 64'(acks), 64'(WPL));
    @(posedge clk); #1;
    check("done_after", {63'd0, lb_done}, 64'd0);
    check("rd_idle", {63'd0, lb_sdram_rd}, 64'd0);
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [15:0] exp);
    DrawX = x;
    DrawY = y;
    pix_q.push_back(exp);
    @(posedge clk); #1;
    check("pixel", {48'd0, pixel_out}, {48'd0, pix_q.pop_front()});
  endtask

  initial begin
    reset = 1'b1; DrawX = '0; DrawY = '0; new_frame = 1'b0;
    lb_sdram_Wait = 1'b0; lb_sdram_ac = 1'b0; lb_sdram_data = '0;
    #2;
    check("rst_rd", {63'd0, lb_sdram_rd}, 64'd0);
    check("rst_addr", {42'd0, lb_sdram_addr}, 64'd0);
    check("rst_busy", {63'd0, lb_Busy}, 64'd0);
    check("rst_done", {63'd0, lb_done}, 64'd0);
    check("rst_overrun", {63'd0, lb_overrun}, 64'd0);
    check("rst_pixel", {48'd0, pixel_out}, 64'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Row 479 at column 799 is not a trigger.
    DrawY = 10'd479; DrawX = 10'd799;
    @(posedge clk); #1;
    DrawX = 10'd0;
    check("no_trigger_479", {63'd0, lb_Busy}, 64'd0);

    // Line 1 into bank 1, then pixel reads from it.
    start_line(10'd0, 1);
    serve(1, -1, -1);
    pix(10'd3, 10'd1, 16'h0003);
    pix(10'd637, 10'd1, exp_pix(1, 637));

    // Line 11 with a 20-cycle Wait stall at W=40.
    start_line(10'd10, 11);
    serve(11, 40, -1);
    pix(10'd3, 10'd11, exp_pix(11, 3));

    // Overrun: trigger during REQ with no acks, clear, set-wins, clear.
    start_line(10'd100, 101);
    DrawX = 10'd799;
    @(posedge clk); #1;
    DrawX = 10'd0;
    check("ovr_set", {63'd0, lb_overrun}, 64'd1);
    check("ovr_addr_held", {42'd0, lb_sdram_addr}, {42'd0, FB + 22'(101 * WPL)});
    new_frame = 1'b1;
    @(posedge clk); #1;
    new_frame = 1'b0;
    check("ovr_clear", {63'd0, lb_overrun}, 64'd0);
    DrawX = 10'd799; new_frame = 1'b1;
    @(posedge clk); #1;
    DrawX = 10'd0; new_frame = 1'b0;
    check("ovr_set_wins", {63'd0, lb_overrun}, 64'd1);
    new_frame = 1'b1;
    @(posedge clk); #1;
    new_frame = 1'b0;
    check("ovr_clear2", {63'd0, lb_overrun}, 64'd0);
    serve(101, -1, -1);

    // Last frame line: lb_done pulses as lb_Busy falls.
    start_line(10'd478, 479);
    serve(479, -1, -1);
    pix(10'd8, 10'd479, exp_pix(479, 8));

    // Reset in the middle of a fetch at W=37.
    start_line(10'd200, 201);
    serve(201, -1, 37);
    check("pre_reset_rd", {63'd0, lb_sdram_rd}, 64'd1);
    check("pre_reset_addr", {42'd0, lb_sdram_addr}, {42'd0, FB + 22'(201 * WPL + 37)});
    reset = 1'b1;
    #1;
    check("midreset_rd", {63'd0, lb_sdram_rd}, 64'd0);
    check("midreset_busy", {63'd0, lb_Busy}, 64'd0);
    check("midreset_addr", {42'd0, lb_sdram_addr}, 64'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_busy", {63'd0, lb_Busy}, 64'd0);
    check("post_reset_rd", {63'd0, lb_sdram_rd}, 64'd0);
    addr_q.delete();

    // Row 524 wraps to line 0 (bank 0); a later bank-1 fetch leaves it intact.
    start_line(10'd524, 0);
    serve(0, -1, -1);
    pix(10'd15, 10'd0, exp_pix(0, 15));
    start_line(10'd2, 3);
    serve(3, -1, -1);
    pix(10'd15, 10'd0, exp_pix(0, 15));
    pix(10'd16, 10'd3, exp_pix(3, 16));

`ifdef LINE_FETCH_BLANK_EN
    pix(10'd700, 10'd3, 16'h0000);
    pix(10'd16, 10'd480, 16'h0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/line_fetch.md
LINE_FETCH -- requirements
Module: line_fetch

Interface
REQ-001 SHALL have parameter FB_BASE, default 22'h000000, SDRAM word address of line 0 word 0.
REQ-002 SHALL have parameter WORDS_PER_LINE, default 80, 128-bit words per 640-pixel line (8 x 16-bit pixels per word).
REQ-003 SHALL have port clk, input, 1, sole clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port DrawX, input, 10, current VGA column (0..799).
REQ-006 SHALL have port DrawY, input, 10, current VGA row (0..524).
REQ-007 SHALL have port new_frame, input, 1, one-cycle frame-start pulse.
REQ-008 SHALL have port lb_sdram_Wait, input, 1, high means the arbiter does not grant this block.
REQ-009 SHALL have port lb_sdram_ac, input, 1, read acknowledge; lb_sdram_data is valid in the same cycle.
REQ-010 SHALL have port lb_sdram_data, input, 128, read data.
REQ-011 SHALL have ports lb_sdram_rd (output, 1, read request) and lb_sdram_addr (output, 22, read word address).
REQ-012 SHALL have ports lb_Busy (output, 1, a line fetch is in progress) and lb_done (output, 1, one-cycle pulse when the last frame line completes).
REQ-013 SHALL have ports pixel_out (output, 16, pixel for the previous cycle's DrawX/DrawY) and lb_overrun (output, 1, sticky flag for a missed fetch).

Function
REQ-014 SHALL use FSM states IDLE, REQ and LAST; reset enters IDLE.
REQ-015 SHALL detect a trigger when DrawX==799 and either DrawY==524 (target line 0) or DrawY<479 (target line DrawY+1).
REQ-016 On a trigger in IDLE, SHALL latch the target line T, clear the word counter W, assert lb_Busy in the next cycle, and go to REQ.
REQ-017 In REQ, SHALL drive lb_sdram_rd = ~lb_sdram_Wait, with lb_sdram_addr = FB_BASE + T*WORDS_PER_LINE + W.
REQ-018 SHALL hold lb_sdram_addr stable until it sees lb_sdram_ac.
REQ-019 SHALL ignore lb_sdram_ac when lb_sdram_rd is low.
REQ-020 On lb_sdram_ac, SHALL write lb_sdram_data into buffer bank T[0] at word W and increment W in the same cycle.
REQ-021 When the acknowledged word is W==WORDS_PER_LINE-1, SHALL go to LAST.
REQ-022 LAST SHALL last exactly one cycle: lb_Busy deasserts, lb_done is 1 if T==479, and the state returns to IDLE.
REQ-023 In IDLE and LAST, lb_sdram_rd SHALL be 0.
REQ-024 A trigger while not in IDLE SHALL be dropped and SHALL set lb_overrun.
REQ-025 new_frame SHALL clear lb_overrun; if a set and a clear occur in the same cycle, the set wins.
REQ-026 The pixel buffer SHALL have 2 banks x WORDS_PER_LINE x 128 bits.
REQ-027 The display side SHALL read bank DrawY[0], word DrawX[9:3], pixel bits [16*DrawX[2:0]+15 : 16*DrawX[2:0]], and register the result into pixel_out (latency 1).
REQ-028 A fetch SHALL write only the bank not being displayed.
REQ-029 W SHALL be 7 bits and T 9 bits, and the address SHALL be computed at 22 bits.

Reset
REQ-030 On reset, the block SHALL immediately set: state IDLE, lb_sdram_rd=0, lb_sdram_addr=0, lb_Busy=0, lb_done=0, lb_overrun=0, pixel_out=0, W=0, T=0.
REQ-031 Reset during REQ SHALL abandon the fetch; buffer contents are undefined and need not be cleared.

Configuration
REQ-032 With LINE_FETCH_BLANK_EN defined, pixel_out SHALL register 16'h0000 whenever DrawX>=640 or DrawY>=480.
REQ-033 Without LINE_FETCH_BLANK_EN, pixel_out SHALL always register the raw buffer value.

Verification
REQ-034 Reset test: assert reset mid-REQ with W=37 -> in the same cycle lb_sdram_rd=0 and lb_Busy=0; after release the state is IDLE.
REQ-035 Normal line: DrawY=10, DrawX=799, lb_sdram_Wait=0, ac every 3rd cycle -> 80 reads at addresses FB_BASE+880..959, then lb_Busy falls and lb_done stays 0.
REQ-036 Wait stall: lb_sdram_Wait=1 for 20 cycles mid-line at W=40 -> rd=0 throughout, addr held at +40, and the line completes after Wait falls.
REQ-037 Last line: DrawY=478 trigger, fetch T=479 -> lb_done is high for exactly one cycle, coincident with lb_Busy falling.
REQ-038 Overrun: hold ac=0 across the next DrawX==799 -> lb_overrun=1; after new_frame -> lb_overrun=0.
REQ-039 Pixel path: word 0 of bank 1 = 128'h0007_0006_..._0000, DrawY=1, DrawX=3 -> next cycle pixel_out=16'h0003; with LINE_FETCH_BLANK_EN, DrawX=700 -> pixel_out=0.
